// File: rtl/icache_pkg.sv
// icache_pkg: shared FSM states, geometry helpers and byte select for the instruction cache
package icache_pkg;
  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, MISS_WAIT, RESPOND} state_t;
  localparam int MAX_LINE_BITS = 512;
  function automatic int off_bits(input int line_bytes);
    return $clog2(line_bytes);
  endfunction
  function automatic int idx_bits(input int sets);
    return $clog2(sets);
  endfunction
  function automatic int tag_bits(input int addr_w, input int line_bytes, input int sets);
    return addr_w - $clog2(line_bytes) - $clog2(sets);
  endfunction
  function automatic logic [7:0] byte_sel(input logic [MAX_LINE_BITS-1:0] line, input logic [5:0] off);
    return line[{off, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/icache_way.sv
// icache_way: one way's tag/valid/data array with combinational read and tag compare
module icache_way #(
  parameter int SETS   = 8,
  parameter int IDX_W  = 3,
  parameter int TAG_W  = 24,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [TAG_W-1:0]  tag,
  input  logic [LINE_W-1:0] wline,
  output logic              valid,
  output logic              hit,
  output logic [LINE_W-1:0] line
);
  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [LINE_W-1:0] data_q [SETS];
  always_ff @(posedge clk) begin
    if (!reset || clr) valid_q <= '0;
    else if (we) valid_q[idx] <= 1'b1;
    if (we) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= wline;
    end
  end
  assign valid = valid_q[idx];
  assign hit   = valid && tag_q[idx] == tag;
  assign line  = data_q[idx];
endmodule

// File: rtl/icache_assoc.sv
// icache_assoc: N-way set-associative read-only instruction cache with line refill FSM
module icache_assoc
  import icache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int WAYS       = 2,
  parameter int SETS       = 8,
  parameter int LINE_BYTES = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  input  logic [ADDR_W-1:0]       req_addr,
  output logic                    req_ready,
  output logic                    resp_valid,
  output logic                    resp_hit,
  output logic [7:0]              resp_data,
  input  logic                    flush,
  output logic                    mem_req_valid,
  output logic [ADDR_W-1:0]       mem_req_addr,
  input  logic                    mem_req_ready,
  input  logic                    mem_resp_valid,
  input  logic [8*LINE_BYTES-1:0] mem_resp_data
);
  localparam int OFF_W  = off_bits(LINE_BYTES);
  localparam int IDX_W  = idx_bits(SETS);
  localparam int TAG_W  = tag_bits(ADDR_W, LINE_BYTES, SETS);
  localparam int LINE_W = 8 * LINE_BYTES;
  localparam int PTR_W  = WAYS > 1 ? $clog2(WAYS) : 1;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0] byte_q;
  logic flush_pend, fill, clr, use_ptr, hit_any;
  logic [PTR_W-1:0] ptr_q [SETS];
  logic [PTR_W-1:0] victim;
  logic [WAYS-1:0] hit, vld;
  logic [LINE_W-1:0] lines [WAYS];
  logic [MAX_LINE_BITS-1:0] hit_line, fill_line;
  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] off;
  assign tag = addr_q[ADDR_W-1 -: TAG_W];
  assign idx = addr_q[OFF_W +: IDX_W];
  assign off = addr_q[OFF_W-1:0];
  assign hit_any = |hit;
  assign fill = reset && state_q == MISS_WAIT && mem_resp_valid;
  // a pending flush is applied on whichever edge returns the FSM to IDLE
  assign clr = (flush || flush_pend) && state_d == IDLE;
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_way #(.SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W), .LINE_W(LINE_W)) u_way (
      .clk(clk), .reset(reset), .clr(clr), .we(fill && victim == PTR_W'(w)),
      .idx(idx), .tag(tag), .wline(mem_resp_data),
      .valid(vld[w]), .hit(hit[w]), .line(lines[w])
    );
  end
  always_comb begin
    hit_line = '0;
    fill_line = '0;
    fill_line[LINE_W-1:0] = mem_resp_data;
    victim = ptr_q[idx];
    use_ptr = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit[w]) hit_line[LINE_W-1:0] = lines[w];
      if (!vld[w]) begin
        victim = PTR_W'(w);
        use_ptr = 1'b0;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = req_valid && req_ready ? LOOKUP : IDLE;
      LOOKUP:    state_d = hit_any ? IDLE : MISS_REQ;
      MISS_REQ:  state_d = mem_req_ready ? MISS_WAIT : MISS_REQ;
      MISS_WAIT: state_d = mem_resp_valid ? RESPOND : MISS_WAIT;
      default:   state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      flush_pend <= 1'b0;
      for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
    end else begin
      state_q <= state_d;
      flush_pend <= state_d != IDLE && (flush_pend || flush);
      if (state_q == IDLE && state_d == LOOKUP) addr_q <= req_addr;
      if (fill) begin
        byte_q <= byte_sel(fill_line, 6'(off));
        if (use_ptr) ptr_q[idx] <= ptr_q[idx] == PTR_W'(WAYS - 1) ? '0 : ptr_q[idx] + 1'b1;
      end
    end
  end
  assign req_ready     = reset && state_q == IDLE && !flush;
  assign resp_hit      = state_q == LOOKUP && hit_any;
  assign resp_valid    = resp_hit || state_q == RESPOND;
  assign resp_data     = resp_hit ? byte_sel(hit_line, 6'(off)) : state_q == RESPOND ? byte_q : 8'h00;
  assign mem_req_valid = state_q == MISS_REQ;
  assign mem_req_addr  = mem_req_valid ? {tag, idx, {OFF_W{1'b0}}} : '0;
  assert property (@(posedge clk) disable iff (!reset) state_q == LOOKUP |-> $onehot0(hit));
endmodule
